product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/booth_pkg.sv | 14 +
 rtl/sat_add.sv | 30 +++
 rtl/product_accumulator.sv | 116 +++++++++++
 tb/tb_product_accumulator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth-multiplier accumulation slice.
//   PROD_W  : width of a signed product coming out of the 4x4 Booth multiplier
//   state_t : control states of the product accumulator
package booth_pkg;

    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder.
// Ports:
//   a, b  : signed W-bit operands
//   sum   : a + b, clamped to the signed W-bit range
//   clamp : high when the true sum did not fit and was clamped
module sat_add #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                clamp
);

    logic [W:0] wide;

    // One guard bit makes overflow visible: the two top bits of the
    // W+1-bit sum disagree exactly when the result left the W-bit range,
    // and the guard bit then tells which bound to clamp to.
    always_comb begin
        wide  = {a[W-1], a} + {b[W-1], b};
        clamp = wide[W] ^ wide[W-1];
        if (clamp) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum = wide[W-1:0];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates len+1 signed Booth products into a saturating sum.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   start, len : begin an accumulation of len+1 terms (sampled in IDLE only)
//   in_valid / in_ready / in_data    : product input handshake
//   out_valid / out_ready / out_data : result output handshake
//   out_sat    : a clamp happened somewhere in this accumulation
//   busy       : block is not in IDLE
module product_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PROD_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    busy
);

    state_t                  state;
    state_t                  next_state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic                    clamp;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        len_q;
    logic                    sat;
    logic                    transfer;

    assign term     = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
    assign transfer = (state == ACCUM) && in_valid;

    sat_add #(.W(ACC_W)) u_sat_add (
        .a     (acc),
        .b     (term),
        .sum   (sum),
        .clamp (clamp)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; the final term is recognised by
    // the count matching the latched length on the cycle it transfers.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (count == len_q)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: a start clears the run and captures its length; each
    // accepted product adds into the accumulator, and any clamp is
    // remembered until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            len_q <= '0;
            sat   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc   <= '0;
            count <= '0;
            len_q <= len;
            sat   <= 1'b0;
        end else if (transfer) begin
            acc   <= sum;
            count <= count + 1'b1;
            if (clamp) begin
                sat <= 1'b1;
            end
        end
    end

    assign out_data = acc;
    assign out_sat  = sat;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. Two instances (ACC_W=12 and
// ACC_W=9) share the same stimulus; a behavioural model predicts both.
module tb_product_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        len;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_ready;

    logic               in_ready12, out_valid12, out_sat12, busy12;
    logic signed [11:0] out_data12;
    logic               in_ready9, out_valid9, out_sat9, busy9;
    logic signed [8:0]  out_data9;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    bit cmp_on = 0;

    // Model state: terms still expected, result pending, exact sums.
    int m_left    = 0;
    bit m_pending = 0;
    int m_acc12   = 0;
    int m_acc9    = 0;
    bit m_sat12   = 0;
    bit m_sat9    = 0;

    always #5 clk = ~clk;

    product_accumulator dut12 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data),
        .out_valid(out_valid12), .out_ready(out_ready),
        .out_data(out_data12), .out_sat(out_sat12), .busy(busy12)
    );

    product_accumulator #(.ACC_W(9), .CNT_W(4)) dut9 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
        .out_valid(out_valid9), .out_ready(out_ready),
        .out_data(out_data9), .out_sat(out_sat9), .busy(busy9)
    );

    function automatic int satModel(input int v, input int w, output bit clamped);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        clamped = 1'b0;
        if (v > hi) begin
            clamped = 1'b1;
            return hi;
        end
        if (v < lo) begin
            clamped = 1'b1;
            return lo;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input int l, input bit v, input int d, input bit r);
        @(posedge clk);
        #1;
        start     = s;
        len       = 4'(l);
        in_valid  = v;
        in_data   = 8'(d);
        out_ready = r;
    endtask

    task automatic startAccum(input int l);
        applyStimulus(1, l, 0, 0, 0);
    endtask

    // len is driven with junk while terms flow; it must not matter.
    task automatic feedTerm(input int d);
        applyStimulus(0, 15, 1, d, 0);
    endtask

    // Waits (bounded) for the result, checks it, then accepts it.
    task automatic drainResult(input string name, input int d12, input int s12,
                               input int d9, input int s9);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid12 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " out_valid"}, out_valid12, 1);
        checkOutput({name, " out_data12"}, out_data12, d12);
        checkOutput({name, " out_sat12"}, out_sat12, s12);
        checkOutput({name, " out_data9"}, out_data9, d9);
        checkOutput({name, " out_sat9"}, out_sat9, s9);
        applyStimulus(0, 0, 0, 0, 1);
    endtask

    // Behavioural model: what each accepted input must do to the sums.
    always @(posedge clk or posedge rst) begin
        bit c;
        if (rst) begin
            m_left = 0; m_pending = 0;
            m_acc12 = 0; m_acc9 = 0; m_sat12 = 0; m_sat9 = 0;
        end else if (m_pending) begin
            if (out_ready) m_pending = 0;
        end else if (m_left > 0) begin
            if (in_valid) begin
                m_acc12 = satModel(m_acc12 + int'(in_data), 12, c);
                if (c) m_sat12 = 1;
                m_acc9 = satModel(m_acc9 + int'(in_data), 9, c);
                if (c) m_sat9 = 1;
                m_left--;
                if (m_left == 0) m_pending = 1;
            end
        end else if (start) begin
            m_left = int'(len) + 1;
            m_acc12 = 0; m_acc9 = 0; m_sat12 = 0; m_sat9 = 0;
        end
    end

    // Compare every cycle, and count handshakes that the next edge takes.
    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("cyc in_ready12", in_ready12, int'(m_left > 0));
            checkOutput("cyc out_valid12", out_valid12, int'(m_pending));
            checkOutput("cyc busy12", busy12, int'(m_left > 0 || m_pending));
            checkOutput("cyc out_data12", out_data12, m_acc12);
            checkOutput("cyc out_sat12", out_sat12, int'(m_sat12));
            checkOutput("cyc in_ready9", in_ready9, int'(m_left > 0));
            checkOutput("cyc out_valid9", out_valid9, int'(m_pending));
            checkOutput("cyc busy9", busy9, int'(m_left > 0 || m_pending));
            checkOutput("cyc out_data9", out_data9, m_acc9);
            checkOutput("cyc out_sat9", out_sat9, int'(m_sat9));
        end
        if (in_valid && in_ready12) xfers++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1; start = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 0;
        @(posedge clk);
        #1 cmp_on = 1;
        @(negedge clk);
        checkOutput("reset in_ready", in_ready12, 0);
        checkOutput("reset out_data", out_data12, 0);
        checkOutput("reset busy", busy12, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rst = 0;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] four-term sum and latency");
        startAccum(3);
        feedTerm(10); feedTerm(-3); feedTerm(64); feedTerm(-56);
        @(negedge clk);
        checkOutput("t1 valid before last edge", out_valid12, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 valid one cycle after", out_valid12, 1);
        checkOutput("t1 out_data", out_data12, 15);
        checkOutput("t1 out_sat", out_sat12, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 idle after accept", busy12, 0);

        $display("[TB] gapped input, start ignored in ACCUM");
        xfers = 0;
        startAccum(1);
        feedTerm(5);
        repeat (3) applyStimulus(1, 9, 0, 99, 0);
        feedTerm(7);
        drainResult("t2", 12, 0, 12, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2 transfers", xfers, 2);

        $display("[TB] saturation");
        startAccum(7);
        repeat (8) feedTerm(64);
        drainResult("t3a", 512, 0, 255, 1);
        startAccum(0);
        feedTerm(1);
        @(negedge clk);
        checkOutput("t6 sat cleared by start", out_sat9, 0);
        drainResult("t6a", 1, 0, 1, 0);
        startAccum(0);
        feedTerm(2);
        drainResult("t6b", 2, 0, 2, 0);
        startAccum(7);
        repeat (8) feedTerm(-56);
        drainResult("t3b", -448, 0, -256, 1);
        startAccum(1);
        repeat (2) feedTerm(-128);
        drainResult("t3c", -256, 0, -256, 0);
        startAccum(2);
        repeat (3) feedTerm(-128);
        drainResult("t3d", -384, 0, -256, 1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] output stall with start pulses");
        startAccum(0);
        feedTerm(20);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4 valid", out_valid12, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i % 2, 5, 0, 0, 0);
            @(negedge clk);
            checkOutput("t4 stall valid", out_valid12, 1);
            checkOutput("t4 stall data", out_data12, 20);
        end
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4 idle after accept", busy12, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4 no restart", busy12, 0);

        $display("[TB] reset mid-accumulation");
        startAccum(3);
        feedTerm(30);
        feedTerm(40);
        @(posedge clk);
        #3 rst = 1;
        in_valid = 0;
        #1;
        checkOutput("t5 rst in_ready", in_ready12, 0);
        checkOutput("t5 rst out_valid", out_valid12, 0);
        checkOutput("t5 rst out_data", out_data12, 0);
        checkOutput("t5 rst out_sat", out_sat12, 0);
        checkOutput("t5 rst busy", busy12, 0);
        checkOutput("t5 rst out_data9", out_data9, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rst = 0;
        startAccum(0);
        feedTerm(-8);
        drainResult("t5", -8, 0, -8, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
